// File: rtl/hazard_sequencer_if.sv
// Hazard unit bundle: pipeline hazard inputs and stall/flush/forward outputs.
// master is the pipeline side, slave is the hazard_sequencer side.
interface hazard_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic             MemReqM;
  logic             MemReadyM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MemTimeout;
  logic [WIDTH-1:0] StallCount;
  logic [WIDTH-1:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    output ResultSrcE, PCSrcE,
    output RdM, RegWriteM, MemReqM, MemReadyM,
    output RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  MemTimeout, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    input  ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, MemReqM, MemReadyM,
    input  RdW, RegWriteW,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output MemTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush/forward controller with memory wait-state FSM and timeout.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_sequencer #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_sequencer_if.slave hz
);

  localparam int WAIT_CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE =
    WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST =
    WAIT_CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FAULT
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [WAIT_CNT_W-1:0] wcnt_q;
  logic [WAIT_CNT_W-1:0] wcnt_d;

  logic mem_stall;
  logic lw_stall;
  logic stall_f;
  logic stall_d;
  logic stall_e;
  logic stall_m;
  logic flush_d;
  logic flush_e;
  logic flush_w;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Ready has priority over the timeout check on the last wait cycle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_d = S_WAIT;
          wcnt_d  = CNT_ONE;
        end
      end
      S_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wcnt_d = wcnt_q + CNT_ONE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      S_IDLE:  mem_stall = hz.MemReqM && !hz.MemReadyM;
      S_WAIT:  mem_stall = !hz.MemReadyM;
      S_FAULT: mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  assign lw_stall = (hz.ResultSrcE == 2'b01) &&
                    (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) ||
                     (hz.RdE == hz.Rs2D));

  // Priority: memory wait, then redirect, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      stall_f = 1'b0;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM,
                      hz.RdW, hz.RegWriteW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM,
                      hz.RdW, hz.RegWriteW);
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.MemTimeout = (state_q == S_FAULT);

`ifdef HAZARD_PERF_EN
  logic [WIDTH-1:0] stall_cnt_q;
  logic [WIDTH-1:0] stall_cnt_d;
  logic [WIDTH-1:0] flush_cnt_q;
  logic [WIDTH-1:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + WIDTH'(stall_f);
    flush_cnt_d = flush_cnt_q + WIDTH'(flush_e);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`else
  assign hz.StallCount = '0;
  assign hz.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MAX_WAIT=4).
module tb_hazard_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  hazard_sequencer_if #(.WIDTH(32)) hz ();

  hazard_sequencer #(
    .WIDTH   (32),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.Rs1D       = '0;
    hz.Rs2D       = '0;
    hz.Rs1E       = '0;
    hz.Rs2E       = '0;
    hz.RdE        = '0;
    hz.ResultSrcE = '0;
    hz.PCSrcE     = 1'b0;
    hz.RdM        = '0;
    hz.RegWriteM  = 1'b0;
    hz.MemReqM    = 1'b0;
    hz.MemReadyM  = 1'b0;
    hz.RdW        = '0;
    hz.RegWriteW  = 1'b0;
  endtask

  int exp_sc;
  int exp_fc;

  initial begin
    total  = 0;
    passed = 0;
    idle_inputs();
    rst = 1'b0;
    // Hazard-provoking inputs while in reset: outputs must stay 0.
    hz.Rs1E       = 5'd7;
    hz.RdM        = 5'd7;
    hz.RegWriteM  = 1'b1;
    hz.MemReqM    = 1'b1;
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd5;
    hz.Rs1D       = 5'd5;
    #2;
    chk("rst_stallf", 32'(hz.StallF), 32'd0);
    chk("rst_flushe", 32'(hz.FlushE), 32'd0);
    chk("rst_flushw", 32'(hz.FlushW), 32'd0);
    chk("rst_fwda", 32'(hz.ForwardAE), 32'd0);
    chk("rst_timeout", 32'(hz.MemTimeout), 32'd0);
    chk("rst_scount", hz.StallCount, 32'd0);
    step();
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("idle_stallf", 32'(hz.StallF), 32'd0);

    // Load-use, two cycles.
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd5;
    hz.Rs1D       = 5'd5;
    #1;
    chk("lu_stallf", 32'(hz.StallF), 32'd1);
    chk("lu_stalld", 32'(hz.StallD), 32'd1);
    chk("lu_flushe", 32'(hz.FlushE), 32'd1);
    chk("lu_flushd", 32'(hz.FlushD), 32'd0);
    chk("lu_stalle", 32'(hz.StallE), 32'd0);
    chk("lu_fwda", 32'(hz.ForwardAE), 32'd0);
    step();
    chk("lu2_stallf", 32'(hz.StallF), 32'd1);
    step();

    // Branch wins over load-use.
    hz.Rs1D   = 5'd0;
    hz.Rs2D   = 5'd5;
    hz.PCSrcE = 1'b1;
    #1;
    chk("br_flushd", 32'(hz.FlushD), 32'd1);
    chk("br_flushe", 32'(hz.FlushE), 32'd1);
    chk("br_stallf", 32'(hz.StallF), 32'd0);
    chk("br_stalld", 32'(hz.StallD), 32'd0);
    step();
    idle_inputs();
    #1;
`ifdef HAZARD_PERF_EN
    exp_sc = 2;
    exp_fc = 3;
`else
    exp_sc = 0;
    exp_fc = 0;
`endif
    chk("perf_stall", hz.StallCount, 32'(exp_sc));
    chk("perf_flush", hz.FlushCount, 32'(exp_fc));

    // RdE = x0 never causes a load-use stall.
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd0;
    #1;
    chk("lu_x0", 32'(hz.StallF), 32'd0);
    idle_inputs();

    // Forwarding priority.
    hz.Rs1E      = 5'd7;
    hz.RdM       = 5'd7;
    hz.RegWriteM = 1'b1;
    hz.RdW       = 5'd7;
    hz.RegWriteW = 1'b1;
    #1;
    chk("fwd_m", 32'(hz.ForwardAE), 32'd2);
    hz.RdM = 5'd0;
    #1;
    chk("fwd_w", 32'(hz.ForwardAE), 32'd1);
    hz.RdW = 5'd0;
    #1;
    chk("fwd_none", 32'(hz.ForwardAE), 32'd0);
    hz.Rs2E = 5'd3;
    hz.RdW  = 5'd3;
    #1;
    chk("fwd_b_w", 32'(hz.ForwardBE), 32'd1);
    hz.RdM = 5'd3;
    hz.RegWriteW = 1'b0;
    #1;
    chk("fwd_b_m", 32'(hz.ForwardBE), 32'd2);
    hz.RegWriteM = 1'b0;
    #1;
    chk("fwd_b_off", 32'(hz.ForwardBE), 32'd0);
    idle_inputs();
    step();

    // Memory wait: three stalled cycles then ready.
    hz.MemReqM   = 1'b1;
    hz.MemReadyM = 1'b0;
    #1;
    chk("mw0_stallf", 32'(hz.StallF), 32'd1);
    chk("mw0_stallm", 32'(hz.StallM), 32'd1);
    chk("mw0_flushw", 32'(hz.FlushW), 32'd1);
    step();
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd5;
    hz.Rs1D       = 5'd5;
    hz.PCSrcE     = 1'b1;
    #1;
    chk("mw1_stalle", 32'(hz.StallE), 32'd1);
    chk("mw1_no_flushe", 32'(hz.FlushE), 32'd0);
    chk("mw1_no_flushd", 32'(hz.FlushD), 32'd0);
    step();
    hz.ResultSrcE = 2'b00;
    hz.PCSrcE     = 1'b0;
    #1;
    chk("mw2_stalld", 32'(hz.StallD), 32'd1);
    step();
    hz.MemReadyM = 1'b1;
    #1;
    chk("mw_rdy_stallf", 32'(hz.StallF), 32'd0);
    chk("mw_rdy_stallm", 32'(hz.StallM), 32'd0);
    chk("mw_rdy_flushw", 32'(hz.FlushW), 32'd0);
    step();
    idle_inputs();
    #1;
    chk("mw_idle_stallf", 32'(hz.StallF), 32'd0);
    chk("mw_idle_tmo", 32'(hz.MemTimeout), 32'd0);
    // Back in IDLE: a fresh request stalls at once.
    hz.MemReqM = 1'b1;
    #1;
    chk("mw_idle_req", 32'(hz.StallF), 32'd1);
    hz.MemReadyM = 1'b1;
    #1;
    chk("mw_idle_hit", 32'(hz.StallF), 32'd0);
    idle_inputs();
    step();

    // Timeout: FAULT four cycles after the request.
    hz.MemReqM   = 1'b1;
    hz.MemReadyM = 1'b0;
    step();
    step();
    step();
    chk("to_pre", 32'(hz.MemTimeout), 32'd0);
    step();
    chk("to_fault", 32'(hz.MemTimeout), 32'd1);
    hz.MemReqM = 1'b0;
    #1;
    chk("to_stallf", 32'(hz.StallF), 32'd1);
    chk("to_flushw", 32'(hz.FlushW), 32'd1);
    step();
    hz.MemReadyM = 1'b1;
    #1;
    chk("to_sticky", 32'(hz.MemTimeout), 32'd1);
    chk("to_held", 32'(hz.StallM), 32'd1);

    // Asynchronous reset mid-FAULT.
    #1;
    rst = 1'b0;
    #1;
    chk("ar_tmo", 32'(hz.MemTimeout), 32'd0);
    chk("ar_stallf", 32'(hz.StallF), 32'd0);
    chk("ar_flushw", 32'(hz.FlushW), 32'd0);
    chk("ar_scount", hz.StallCount, 32'd0);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    chk("post_tmo", 32'(hz.MemTimeout), 32'd0);
    chk("post_stallf", 32'(hz.StallF), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central hazard/stall/flush controller for the 5-stage RV32I pipeline.
- Drives stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers, and forwarding selects into Execute.
- Sequences multi-cycle data-memory accesses with a wait-state FSM and timeout.
- Resolves load-use, branch-redirect and memory-wait hazards with fixed priority.

Parameters:
- WIDTH, 32: width of performance counters.
- MAX_WAIT, 16: max memory wait cycles before timeout; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E  in  5  source registers in Execute.
- RdE  in  5  destination register in Execute.
- ResultSrcE  in  2  result select in Execute; 2'b01 = load.
- PCSrcE  in  1  branch/jump taken in Execute.
- RdM  in  5  destination register in Memory.
- RegWriteM  in  1  register write in Memory.
- MemReqM  in  1  load/store in Memory stage.
- MemReadyM  in  1  data memory completes access this cycle.
- RdW  in  5  destination register in Writeback.
- RegWriteW  in  1  register write in Writeback.
- StallF, StallD, StallE, StallM  out  1  hold the respective pipeline register.
- FlushD, FlushE, FlushW  out  1  load bubble into D/E/W register.
- ForwardAE, ForwardBE  out  2  00 regfile, 10 ALUResultM, 01 ResultW.
- MemTimeout  out  1  sticky memory timeout fault.
- StallCount, FlushCount  out  WIDTH  performance counters (see Optional Feature).

Behaviour:
- Reset (rst=0, async): FSM to IDLE, wait counter 0, MemTimeout 0, counters 0.
  - All stall/flush/forward outputs are 0 while in reset.
- All stall, flush and forward outputs are combinational from FSM state and current inputs (same-cycle response).
- FSM states IDLE, WAIT, FAULT.
  - IDLE -> WAIT when MemReqM=1 and MemReadyM=0; wait counter loads 1.
  - WAIT: counter +1 per cycle.
    - WAIT -> IDLE when MemReadyM=1.
    - WAIT -> FAULT when MemReadyM=0 and counter = MAX_WAIT-1.
  - FAULT: MemTimeout=1; state held until reset.
- mem_stall = (IDLE and MemReqM and !MemReadyM) or (WAIT and !MemReadyM) or FAULT.
  - mem_stall=1: StallF=StallD=StallE=StallM=1, FlushW=1; all other flush outputs 0.
  - Load-use and branch evaluation are suppressed while mem_stall=1.
  - Ready cycle: MemReadyM=1 in WAIT releases all stalls in that same cycle.
- lw_stall = (ResultSrcE==2'b01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- When mem_stall=0:
  - PCSrcE=1: FlushD=1, FlushE=1, StallF=StallD=0. Branch wins over lw_stall.
  - Else lw_stall=1: StallF=StallD=1, FlushE=1.
  - StallE, StallM, FlushW are 0.
- ForwardAE:
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Else 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Else 00. The Memory-stage match takes priority.
  - ForwardBE is identical, using Rs2E.
- Wait counter is WAIT_CNT_W = $clog2(MAX_WAIT)+1 bits and never wraps.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - StallCount +1 every cycle StallF=1.
  - FlushCount +1 every cycle FlushE=1.
  - Both wrap modulo 2^WIDTH; both are cleared by reset.
- Undefined: StallCount and FlushCount are tied to 0; no counter flops are synthesised.

Test Plan:
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5, PCSrcE=0 -> StallF=StallD=FlushE=1, StallE=0, Forward=00.
- Branch + load-use same cycle: PCSrcE=1, ResultSrcE=01, RdE=5, Rs2D=5 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles; all 0 on the ready cycle; FSM back to IDLE.
- Timeout: MAX_WAIT=4, MemReqM=1, MemReadyM held 0 -> FAULT reached 4 cycles after request; MemTimeout=1 and stalls held. Async rst=0 mid-FAULT -> all outputs 0 immediately.
- Forwarding priority: Rs1E=7, RdM=7, RegWriteM=1, RdW=7, RegWriteW=1 -> ForwardAE=10. Same with RdM=0 -> 01. RdW=0 as well -> 00.
- HAZARD_PERF_EN defined: 2 load-use cycles + 1 branch -> StallCount=2, FlushCount=3. Undefined -> both read 0.
